// File: rtl/ssd1306_pkg.sv
// Shared constants and types for the SSD1306 I2C target model.
// FSM encoding, command/control byte values and bus event bundle.
package ssd1306_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_CTRL     = 3'd3;
    localparam logic [2:0] ST_CTRL_ACK = 3'd4;
    localparam logic [2:0] ST_BYTE     = 3'd5;
    localparam logic [2:0] ST_BYTE_ACK = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    localparam logic [7:0] CMD_DISPLAY_OFF = 8'hAE;
    localparam logic [7:0] CMD_DISPLAY_ON  = 8'hAF;
    localparam logic [7:0] CMD_CONTRAST    = 8'h81;

    localparam logic [7:0] CTRL_CMD  = 8'h00;
    localparam logic [7:0] CTRL_DATA = 8'h40;

    localparam int CO_BIT   = 7;
    localparam int DC_BIT   = 6;
    localparam int FB_DEPTH = 1024;
    localparam int FB_AW    = $clog2(FB_DEPTH);

    typedef struct packed {
        logic start;
        logic stop;
        logic rise;
        logic fall;
        logic sda;
    } bus_evt_t;

endpackage

// File: rtl/ssd1306_i2c_target_if.sv
// I2C pin bundle between a bus master and the SSD1306 target.
// The target only ever pulls SDA low; the pad is built above it.
interface ssd1306_i2c_target_if;
    logic scl_in;
    logic sda_in;
    logic sda_oe;

    modport master (output scl_in, output sda_in, input sda_oe);
    modport slave  (input scl_in, input sda_in, output sda_oe);
endinterface

// File: rtl/ssd1306_i2c_target_sync.sv
// Two-flop synchronizers plus history flop for SCL/SDA, and
// single-cycle START/STOP/rise/fall event pulses.
module i2c_bus_sync
    import ssd1306_pkg::*;
(
    input  logic     clk,
    input  logic     rst,
    input  logic     scl_in,
    input  logic     sda_in,
    output bus_evt_t evt
);

    logic [2:0] scl_q;
    logic [2:0] sda_q;

    // Idle bus is high, so reset to 1 to avoid phantom edges
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scl_q <= 3'b111;
            sda_q <= 3'b111;
        end else begin
            scl_q <= {scl_q[1:0], scl_in};
            sda_q <= {sda_q[1:0], sda_in};
        end
    end

    assign evt.sda   = sda_q[1];
    assign evt.rise  = scl_q[1] & ~scl_q[2];
    assign evt.fall  = ~scl_q[1] & scl_q[2];
    assign evt.start = scl_q[1] & ~sda_q[1] & sda_q[2];
    assign evt.stop  = scl_q[1] & sda_q[1] & ~sda_q[2];

endmodule

// File: rtl/ssd1306_i2c_target.sv
// SSD1306 write-path emulation: I2C target decoding address,
// control and payload bytes into pixel writes and commands.
module ssd1306_i2c_target
    import ssd1306_pkg::*;
#(
    parameter logic [6:0] ADDRESS = 7'h3C
) (
    input  logic                   clk,
    input  logic                   rst,
    ssd1306_i2c_target_if.slave    bus,
    output logic                   pix_we,
    output logic [FB_AW-1:0]       pix_addr,
    output logic [7:0]             pix_wdata,
    output logic                   cmd_valid,
    output logic [7:0]             cmd_byte,
    output logic                   display_on,
    output logic [7:0]             contrast,
    output logic                   busy
);

    bus_evt_t   evt;
    logic [2:0] state;
    logic [2:0] bit_cnt;
    logic [6:0] shreg;
    logic       co;
    logic       dc;
    logic       pfx;
    logic       sda_oe_q;
    logic [7:0] byte_nxt;
    logic       shifting;

    i2c_bus_sync u_sync (
        .clk    (clk),
        .rst    (rst),
        .scl_in (bus.scl_in),
        .sda_in (bus.sda_in),
        .evt    (evt)
    );

    assign bus.sda_oe = sda_oe_q;
    assign byte_nxt   = {shreg, evt.sda};
    assign shifting   = (state == ST_ADDR) || (state == ST_CTRL) ||
                        (state == ST_BYTE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 7'd0;
            co         <= 1'b0;
            dc         <= 1'b0;
            pfx        <= 1'b0;
            sda_oe_q   <= 1'b0;
            pix_we     <= 1'b0;
            pix_addr   <= '0;
            pix_wdata  <= 8'd0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= 8'd0;
            display_on <= 1'b0;
            contrast   <= 8'h7F;
            busy       <= 1'b0;
        end else begin
            pix_we    <= 1'b0;
            cmd_valid <= 1'b0;

            if (pix_we)
                pix_addr <= pix_addr + 10'd1;

            // Command side effects land one cycle after the strobe
            if (cmd_valid) begin
                if (pfx) begin
                    contrast <= cmd_byte;
                    pfx      <= 1'b0;
                end else begin
                    pfx <= (cmd_byte == CMD_CONTRAST);
                    if (cmd_byte == CMD_DISPLAY_OFF)
                        display_on <= 1'b0;
                    if (cmd_byte == CMD_DISPLAY_ON)
                        display_on <= 1'b1;
                end
            end

            if (evt.stop) begin
                state    <= ST_IDLE;
                sda_oe_q <= 1'b0;
                busy     <= 1'b0;
                pfx      <= 1'b0;
            end else if (evt.start) begin
                state    <= ST_ADDR;
                bit_cnt  <= 3'd0;
                sda_oe_q <= 1'b0;
                pfx      <= 1'b0;
            end else if (shifting && evt.rise) begin
                shreg   <= byte_nxt[6:0];
                bit_cnt <= bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) begin
                    case (state)
                        ST_ADDR: begin
                            if (byte_nxt[7:1] == ADDRESS && !byte_nxt[0]) begin
                                state <= ST_ADDR_ACK;
                                busy  <= 1'b1;
                            end else begin
                                state <= ST_IGNORE;
                                busy  <= 1'b0;
                            end
                        end
                        ST_CTRL: begin
                            co    <= byte_nxt[CO_BIT];
                            dc    <= byte_nxt[DC_BIT];
                            state <= ST_CTRL_ACK;
                        end
                        default: begin
                            if (dc) begin
                                pix_we    <= 1'b1;
                                pix_wdata <= byte_nxt;
                            end else begin
                                cmd_valid <= 1'b1;
                                cmd_byte  <= byte_nxt;
                            end
                            state <= ST_BYTE_ACK;
                        end
                    endcase
                end
            end else if (evt.fall) begin
                // First fall after bit 8 drives ACK, the next releases it
                case (state)
                    ST_ADDR_ACK, ST_CTRL_ACK, ST_BYTE_ACK: begin
                        sda_oe_q <= ~sda_oe_q;
                        if (sda_oe_q) begin
                            bit_cnt <= 3'd0;
                            if (state == ST_ADDR_ACK)
                                state <= ST_CTRL;
                            else if (state == ST_CTRL_ACK)
                                state <= ST_BYTE;
                            else
                                state <= co ? ST_CTRL : ST_BYTE;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ssd1306_i2c_target.sv
// Scoreboard bench for ssd1306_i2c_target driving an I2C master
// model with SCL at 8x oversampling.
module tb_ssd1306_i2c_target;
    import ssd1306_pkg::*;

    typedef struct packed {
        logic [9:0] a;
        logic [7:0] d;
    } pix_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       scl = 1'b1;
    logic       sda_m = 1'b1;
    logic       pix_we;
    logic [9:0] pix_addr;
    logic [7:0] pix_wdata;
    logic       cmd_valid;
    logic [7:0] cmd_byte;
    logic       display_on;
    logic [7:0] contrast;
    logic       busy;

    int   checks = 0;
    int   failures = 0;
    int   oe_cnt = 0;
    int   busy_cnt = 0;
    int   oe_base;
    int   busy_base;
    pix_t exp_pix[$];
    logic [7:0] exp_cmd[$];
    logic [9:0] exp_addr = 10'd0;

    logic [7:0] init_seq [25] = '{
        8'hAE, 8'hD5, 8'h80, 8'hA8, 8'h3F, 8'hD3, 8'h00, 8'h40,
        8'h8D, 8'h14, 8'h20, 8'h00, 8'hA1, 8'hC8, 8'hDA, 8'h12,
        8'hD9, 8'hF1, 8'hDB, 8'h40, 8'hA4, 8'hA6, 8'hAF, 8'h81,
        8'hFF
    };

    always #5 clk = ~clk;

    ssd1306_i2c_target_if bus ();

    assign bus.scl_in = scl;
    assign bus.sda_in = sda_m & ~bus.sda_oe;

    ssd1306_i2c_target #(.ADDRESS(7'h3C)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .pix_we     (pix_we),
        .pix_addr   (pix_addr),
        .pix_wdata  (pix_wdata),
        .cmd_valid  (cmd_valid),
        .cmd_byte   (cmd_byte),
        .display_on (display_on),
        .contrast   (contrast),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.sda_oe === 1'b1)
                oe_cnt++;
            if (busy === 1'b1)
                busy_cnt++;
            if (pix_we === 1'b1) begin
                check("pix_q", 32'(exp_pix.size() != 0), 1);
                if (exp_pix.size() != 0) begin
                    pix_t p;
                    p = exp_pix.pop_front();
                    check("pix_addr", 32'(pix_addr), 32'(p.a));
                    check("pix_data", 32'(pix_wdata), 32'(p.d));
                end
            end
            if (cmd_valid === 1'b1) begin
                check("cmd_q", 32'(exp_cmd.size() != 0), 1);
                if (exp_cmd.size() != 0)
                    check("cmd_byte", 32'(cmd_byte), 32'(exp_cmd.pop_front()));
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic put_bit(input logic b);
        wclk(2); sda_m = b;
        wclk(3); scl = 1'b1;
        wclk(3); scl = 1'b0;
    endtask

    task automatic get_ack(output logic a);
        wclk(2); sda_m = 1'b1;
        wclk(3); scl = 1'b1;
        wclk(1); a = ~bus.sda_in;
        wclk(2); scl = 1'b0;
    endtask

    task automatic tx_byte(input logic [7:0] b, input logic exp_ack,
                           input string tag);
        logic a;
        for (int i = 7; i >= 0; i--)
            put_bit(b[i]);
        get_ack(a);
        check(tag, 32'(a), 32'(exp_ack));
    endtask

    task automatic i2c_start;
        wclk(2); sda_m = 1'b1;
        wclk(3); scl = 1'b1;
        wclk(3); sda_m = 1'b0;
        wclk(3); scl = 1'b0;
    endtask

    task automatic i2c_stop;
        wclk(2); sda_m = 1'b0;
        wclk(3); scl = 1'b1;
        wclk(3); sda_m = 1'b1;
        wclk(3);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        exp_cmd.push_back(b);
        tx_byte(b, 1'b1, "cmd_ack");
    endtask

    task automatic send_data(input logic [7:0] b);
        exp_pix.push_back(pix_t'{a: exp_addr, d: b});
        exp_addr = exp_addr + 10'd1;
        tx_byte(b, 1'b1, "data_ack");
    endtask

    task automatic open_tx(input logic [7:0] ctrl);
        i2c_start;
        tx_byte({7'h3C, 1'b0}, 1'b1, "addr_ack");
        tx_byte(ctrl, 1'b1, "ctrl_ack");
    endtask

    task automatic drain_check(input string tag);
        wclk(4);
        check({tag, "_pix_left"}, 32'(exp_pix.size()), 0);
        check({tag, "_cmd_left"}, 32'(exp_cmd.size()), 0);
        check({tag, "_addr"}, 32'(pix_addr), 32'(exp_addr));
        check({tag, "_busy"}, 32'(busy), 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        wclk(3);
        check("rst_sda_oe", 32'(bus.sda_oe), 0);
        check("rst_pix_we", 32'(pix_we), 0);
        check("rst_pix_addr", 32'(pix_addr), 0);
        check("rst_cmd_valid", 32'(cmd_valid), 0);
        check("rst_display", 32'(display_on), 0);
        check("rst_contrast", 32'(contrast), 32'h7F);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        wclk(4);

        i2c_start;
        tx_byte({7'h3C, 1'b0}, 1'b1, "addr_ack");
        check("busy_on", 32'(busy), 1);
        tx_byte(CTRL_CMD, 1'b1, "ctrl_ack");
        foreach (init_seq[i])
            send_cmd(init_seq[i]);
        i2c_stop;
        drain_check("init");
        check("init_display", 32'(display_on), 1);
        check("init_contrast", 32'(contrast), 32'hFF);

        open_tx(CTRL_DATA);
        for (int i = 0; i < 1026; i++)
            send_data(8'(i));
        i2c_stop;
        drain_check("wrap");

        oe_base = oe_cnt;
        busy_base = busy_cnt;
        i2c_start;
        tx_byte({7'h3D, 1'b0}, 1'b0, "nack_w_addr");
        tx_byte(8'h40, 1'b0, "nack_w_byte");
        i2c_stop;
        i2c_start;
        tx_byte({7'h3C, 1'b1}, 1'b0, "nack_r_addr");
        tx_byte(8'hA5, 1'b0, "nack_r_byte");
        i2c_stop;
        drain_check("nack");
        check("nack_oe", 32'(oe_cnt - oe_base), 0);
        check("nack_busy", 32'(busy_cnt - busy_base), 0);

        open_tx(8'h80);
        send_cmd(CMD_DISPLAY_OFF);
        tx_byte(8'hC0, 1'b1, "co_ctrl_ack");
        send_data(8'h5A);
        i2c_stop;
        drain_check("co");
        check("co_display", 32'(display_on), 0);

        open_tx(CTRL_DATA);
        for (int i = 0; i < 5; i++)
            put_bit(1'b1);
        i2c_stop;
        drain_check("cut");
        open_tx(CTRL_DATA);
        send_data(8'h3C);
        i2c_stop;
        drain_check("after_cut");

        open_tx(CTRL_DATA);
        exp_pix.push_back(pix_t'{a: exp_addr, d: 8'h77});
        for (int i = 7; i >= 0; i--)
            put_bit(8'h77 >> i);
        wclk(4);
        check("mid_ack_oe", 32'(bus.sda_oe), 1);
        rst = 1'b1;
        #1;
        exp_addr = 10'd0;
        check("rst_mid_oe", 32'(bus.sda_oe), 0);
        check("rst_mid_addr", 32'(pix_addr), 0);
        check("rst_mid_contrast", 32'(contrast), 32'h7F);
        check("rst_mid_busy", 32'(busy), 0);
        wclk(2);
        rst = 1'b0;
        wclk(1); scl = 1'b1;
        wclk(3); scl = 1'b0;
        i2c_stop;
        open_tx(CTRL_DATA);
        send_data(8'hA5);
        send_data(8'h5A);
        i2c_stop;
        drain_check("recover");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
